// File: rtl/macc_dot_ctrl_if.sv
// ============================================================================
// Module  : macc_dot_ctrl_if
// Brief   : Command, operand, macc-datapath and result signals of one MACC PE
//           sequencer, with controller (slave) and environment (master) views.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface macc_dot_ctrl_if #(
    parameter int ACT_BITWIDTH = 16,
    parameter int WGT_BITWIDTH = 16,
    parameter int ACC_BITWIDTH = 64,
    parameter int LEN_BITWIDTH = 12
);
    logic                    start;
    logic [LEN_BITWIDTH-1:0] len;
    logic                    busy;

    logic                    op_valid;
    logic                    op_ready;
    logic [ACT_BITWIDTH-1:0] a_in;
    logic [WGT_BITWIDTH-1:0] w_in;

    logic [ACT_BITWIDTH-1:0] macc_a;
    logic [WGT_BITWIDTH-1:0] macc_w;
    logic [ACC_BITWIDTH-1:0] macc_sum;
    logic [ACC_BITWIDTH:0]   macc_out;

    logic                    res_valid;
    logic                    res_ready;
    logic [ACC_BITWIDTH-1:0] res_out;
    logic                    res_ovf;

    modport slave (
        input  start, len, op_valid, a_in, w_in, macc_out, res_ready,
        output busy, op_ready, macc_a, macc_w, macc_sum, res_valid, res_out, res_ovf
    );

    modport master (
        output start, len, op_valid, a_in, w_in, macc_out, res_ready,
        input  busy, op_ready, macc_a, macc_w, macc_sum, res_valid, res_out, res_ovf
    );
endinterface

`default_nettype wire

// File: rtl/macc_dot_ctrl.sv
// ============================================================================
// Module  : macc_dot_ctrl
// Brief   : Sequences LEN activation/weight pairs through a combinational macc
//           and returns the accumulated dot product on a valid/ready port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module macc_dot_ctrl #(
    parameter int ACT_BITWIDTH = 16,
    parameter int WGT_BITWIDTH = 16,
    parameter int ACC_BITWIDTH = 64,
    parameter int LEN_BITWIDTH = 12
) (
    input  wire logic     clk,
    input  wire logic     reset,
    macc_dot_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ACC_BITWIDTH-1:0] r_acc;
    logic [LEN_BITWIDTH-1:0] r_cnt;
    logic [LEN_BITWIDTH-1:0] r_len;
    logic                    r_ovf;

    logic w_beat;
    logic w_last;
    logic w_wrap;

    assign w_beat = bus.op_valid && (r_state == S_RUN);
    assign w_last = (r_cnt == r_len - 1'b1);
    // The macc result carries one guard bit; disagreement with the sign bit means wrap.
    assign w_wrap = bus.macc_out[ACC_BITWIDTH] ^ bus.macc_out[ACC_BITWIDTH-1];

    assign bus.macc_a   = bus.a_in;
    assign bus.macc_w   = bus.w_in;
    assign bus.macc_sum = r_acc;
    assign bus.res_out  = r_acc;
    assign bus.res_ovf  = r_ovf;
    assign bus.busy     = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        bus.op_ready  = 1'b0;
        bus.res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                bus.op_ready = 1'b1;
                if (w_beat && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                        if (bus.len != '0) begin
                            r_len <= bus.len;
                        end
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        r_acc <= bus.macc_out[ACC_BITWIDTH-1:0];
                        r_cnt <= r_cnt + 1'b1;
                        r_ovf <= r_ovf | w_wrap;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_macc_dot_ctrl.sv
// ============================================================================
// Module  : tb_macc_dot_ctrl
// Brief   : Drives a 64-bit and a 32-bit accumulator controller in lockstep and
//           checks results against an exact-arithmetic dot-product model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_macc_dot_ctrl;
    logic clk;
    logic reset;

    macc_dot_ctrl_if #(.ACC_BITWIDTH(64)) if64 ();
    macc_dot_ctrl_if #(.ACC_BITWIDTH(32)) if32 ();

    macc_dot_ctrl #(.ACC_BITWIDTH(64)) u_dut64 (.clk(clk), .reset(reset), .bus(if64));
    macc_dot_ctrl #(.ACC_BITWIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(if32));

    // Combinational macc datapaths: {0,a} signed times signed w plus the accumulator.
    always_comb begin
        if64.macc_out = $signed({1'b0, if64.macc_a}) * $signed(if64.macc_w) + $signed(if64.macc_sum);
        if32.macc_out = $signed({1'b0, if32.macc_a}) * $signed(if32.macc_w) + $signed(if32.macc_sum);
    end

    assign if32.start     = if64.start;
    assign if32.len       = if64.len;
    assign if32.op_valid  = if64.op_valid;
    assign if32.a_in      = if64.a_in;
    assign if32.w_in      = if64.w_in;
    assign if32.res_ready = if64.res_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] qa[$];
    logic [15:0] qw[$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Exact-arithmetic step; the result wraps into width bits and flags any excursion.
    function automatic void model_step(input int width, inout logic signed [127:0] acc,
                                       inout bit ovf, input logic [15:0] a, input logic [15:0] w);
        logic signed [127:0] exact, lim, wrapped;
        exact   = acc + (longint'(a) * longint'($signed(w)));
        lim     = 128'sd1 <<< (width - 1);
        if (exact >= lim || exact < -lim) ovf = 1'b1;
        wrapped = exact & ((lim <<< 1) - 1);
        if (wrapped >= lim) wrapped = wrapped - (lim <<< 1);
        acc     = wrapped;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy64"},  64'(if64.busy),      64'd0);
        check({tag, "_busy32"},  64'(if32.busy),      64'd0);
        check({tag, "_rdy64"},   64'(if64.op_ready),  64'd0);
        check({tag, "_rdy32"},   64'(if32.op_ready),  64'd0);
        check({tag, "_rv64"},    64'(if64.res_valid), 64'd0);
        check({tag, "_rv32"},    64'(if32.res_valid), 64'd0);
        check({tag, "_out64"},   if64.res_out,        64'd0);
        check({tag, "_out32"},   64'(if32.res_out),   64'd0);
        check({tag, "_ovf64"},   64'(if64.res_ovf),   64'd0);
        check({tag, "_ovf32"},   64'(if32.res_ovf),   64'd0);
    endtask

    // One job with the operands in qa/qw; gap idle cycles before each beat, hold cycles of backpressure.
    task automatic run_job(input string tag, input int gap, input int hold);
        logic signed [127:0] m64, m32;
        bit o64, o32;
        int n;
        n = qa.size();
        m64 = '0; m32 = '0; o64 = 1'b0; o32 = 1'b0;
        for (int i = 0; i < n; i++) begin
            model_step(64, m64, o64, qa[i], qw[i]);
            model_step(32, m32, o32, qa[i], qw[i]);
        end

        @(negedge clk);
        check({tag, "_idle_rdy"}, 64'(if64.op_ready), 64'd0);
        if64.start = 1'b1;
        if64.len   = 12'(n);
        @(negedge clk);
        if64.start = 1'b0;
        check({tag, "_busy64"}, 64'(if64.busy), 64'd1);
        check({tag, "_busy32"}, 64'(if32.busy), 64'd1);

        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                check({tag, "_gap_rdy"}, 64'(if64.op_ready), 64'd1);
                check({tag, "_gap_rv"},  64'(if64.res_valid), 64'd0);
                if64.start = 1'b1;
                if64.len   = 12'($urandom_range(1, 9));
                @(negedge clk);
                if64.start = 1'b0;
            end
            check({tag, "_rdy64"}, 64'(if64.op_ready), 64'd1);
            check({tag, "_rdy32"}, 64'(if32.op_ready), 64'd1);
            check({tag, "_early_rv"}, 64'(if64.res_valid), 64'd0);
            if64.op_valid = 1'b1;
            if64.a_in     = qa[i];
            if64.w_in     = qw[i];
            @(negedge clk);
            if64.op_valid = 1'b0;
            if64.a_in     = 16'($urandom);
            if64.w_in     = 16'($urandom);
        end

        for (int h = 0; h <= hold; h++) begin
            check({tag, "_rv64"},  64'(if64.res_valid), 64'd1);
            check({tag, "_rv32"},  64'(if32.res_valid), 64'd1);
            check({tag, "_out64"}, if64.res_out, m64[63:0]);
            check({tag, "_out32"}, 64'(if32.res_out), {32'd0, m32[31:0]});
            check({tag, "_ovf64"}, 64'(if64.res_ovf), 64'(o64));
            check({tag, "_ovf32"}, 64'(if32.res_ovf), 64'(o32));
            check({tag, "_done_rdy"}, 64'(if64.op_ready), 64'd0);
            if (h < hold) begin
                if64.start = 1'b1;
                if64.len   = 12'($urandom_range(0, 9));
                @(negedge clk);
                if64.start = 1'b0;
            end
        end

        if64.res_ready = 1'b1;
        @(negedge clk);
        if64.res_ready = 1'b0;
        check({tag, "_end_busy"}, 64'(if64.busy), 64'd0);
        check({tag, "_end_rv32"}, 64'(if32.res_valid), 64'd0);
    endtask

    initial begin
        reset          = 1'b1;
        if64.start     = 1'b0;
        if64.len       = '0;
        if64.op_valid  = 1'b0;
        if64.a_in      = '0;
        if64.w_in      = '0;
        if64.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        qa = '{16'd1, 16'd2, 16'd3, 16'd4};
        qw = '{16'd1, 16'd1, 16'd1, 16'd1};
        run_job("t1_len4", 0, 0);

        qa = '{16'hFFFF};
        qw = '{16'hFFFF};
        run_job("t2_neg", 0, 1);

        qa = {};
        qw = {};
        run_job("t3_len0", 0, 0);

        qa = '{16'($urandom), 16'($urandom), 16'($urandom)};
        qw = '{16'($urandom), 16'($urandom), 16'($urandom)};
        run_job("t4_gaps", 2, 5);

        qa = '{16'd65535, 16'd65535};
        qw = '{16'd32767, 16'd32767};
        run_job("t5_wrap", 0, 0);

        // Asynchronous reset between clock edges after two of four beats.
        @(negedge clk);
        if64.start = 1'b1;
        if64.len   = 12'd4;
        @(negedge clk);
        if64.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if64.op_valid = 1'b1;
            if64.a_in     = 16'($urandom_range(1, 65535));
            if64.w_in     = 16'($urandom_range(1, 32767));
            @(negedge clk);
        end
        if64.op_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_idle_outputs("t6_async");
        @(negedge clk);
        reset = 1'b0;

        qa = '{16'($urandom), 16'($urandom)};
        qw = '{16'($urandom), 16'($urandom)};
        run_job("t6_restart", 0, 0);

        for (int j = 0; j < 6; j++) begin
            int n;
            n = $urandom_range(1, 6);
            qa = {};
            qw = {};
            for (int i = 0; i < n; i++) begin
                qa.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
                qw.push_back(($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom));
            end
            run_job("rand", $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
